// File: rtl/cmu_phi_pipe.sv
// Kalman covariance CMU channel: a = (theta_a + q_a) op (coef_b*theta_b + coef_c*theta_c).
// Fixed-latency binary64 pipe feeding a credit-controlled first-word-fall-through output FIFO.
module cmu_phi_pipe #(
  parameter int unsigned DBL_WIDTH  = 64,
  parameter int unsigned MUL_LAT    = 4,
  parameter int unsigned ADD_LAT    = 3,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned TAG_W      = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [TAG_W-1:0]     in_tag,
  input  logic [1:0]           in_mode,
  input  logic [DBL_WIDTH-1:0] theta_a,
  input  logic [DBL_WIDTH-1:0] q_a,
  input  logic [DBL_WIDTH-1:0] theta_b,
  input  logic [DBL_WIDTH-1:0] coef_b,
  input  logic [DBL_WIDTH-1:0] theta_c,
  input  logic [DBL_WIDTH-1:0] coef_c,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DBL_WIDTH-1:0] out_a,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 busy
);

  localparam int unsigned PipeLat = MUL_LAT + 2 * ADD_LAT;
  localparam int unsigned T1Lat   = MUL_LAT + ADD_LAT;
  localparam int unsigned CntW    = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);

  typedef logic [DBL_WIDTH-1:0] f64_t;

  localparam f64_t QNaN = 64'h7FF8_0000_0000_0000;

  // Round-to-nearest-even; m carries the hidden bit at [52]. Subnormal results flush to zero.
  function automatic f64_t fp_round(input logic s, input logic signed [12:0] e,
                                    input logic [52:0] m, input logic g, input logic st);
    logic [53:0]        r;
    logic signed [12:0] eo;
    logic [51:0]        frac;
    f64_t               res;
    r    = {1'b0, m} + {53'd0, g & (st | m[0])};
    eo   = r[53] ? e + 13'sd1 : e;
    frac = r[53] ? r[52:1] : r[51:0];
    if (eo >= 13'sd2047)   res = {s, 11'h7ff, 52'd0};
    else if (eo <= 13'sd0) res = {s, 63'd0};
    else                   res = {s, eo[10:0], frac};
    return res;
  endfunction

  function automatic f64_t fp_mul(input f64_t a, input f64_t b);
    logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, s;
    logic [105:0]       p;
    logic signed [12:0] e;
    f64_t               res;
    a_nan  = (a[62:52] == 11'h7ff) && (a[51:0] != '0);
    b_nan  = (b[62:52] == 11'h7ff) && (b[51:0] != '0);
    a_inf  = (a[62:52] == 11'h7ff) && (a[51:0] == '0);
    b_inf  = (b[62:52] == 11'h7ff) && (b[51:0] == '0);
    a_zero = a[62:52] == '0;
    b_zero = b[62:52] == '0;
    s      = a[63] ^ b[63];
    p      = {53'd0, 1'b1, a[51:0]} * {53'd0, 1'b1, b[51:0]};
    e      = $signed({2'b00, a[62:52]}) + $signed({2'b00, b[62:52]}) - 13'sd1023;
    if (p[105]) res = fp_round(s, e + 13'sd1, p[105:53], p[52], |p[51:0]);
    else        res = fp_round(s, e, p[104:52], p[51], |p[50:0]);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) res = QNaN;
    else if (a_inf || b_inf)                                      res = {s, 11'h7ff, 52'd0};
    else if (a_zero || b_zero)                                    res = {s, 63'd0};
    return res;
  endfunction

  function automatic f64_t fp_add(input f64_t a, input f64_t b);
    logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, swap, s1, s2, found;
    logic [10:0]        e1, e2, d;
    logic [55:0]        m1, m2_raw, m2, n;
    logic [56:0]        sum;
    logic [5:0]         lz;
    logic signed [12:0] e;
    f64_t               res;
    a_nan  = (a[62:52] == 11'h7ff) && (a[51:0] != '0);
    b_nan  = (b[62:52] == 11'h7ff) && (b[51:0] != '0);
    a_inf  = (a[62:52] == 11'h7ff) && (a[51:0] == '0);
    b_inf  = (b[62:52] == 11'h7ff) && (b[51:0] == '0);
    a_zero = a[62:52] == '0;
    b_zero = b[62:52] == '0;
    swap   = a[62:0] < b[62:0];
    s1     = swap ? b[63] : a[63];
    s2     = swap ? a[63] : b[63];
    e1     = swap ? b[62:52] : a[62:52];
    e2     = swap ? a[62:52] : b[62:52];
    m1     = {1'b1, (swap ? b[51:0] : a[51:0]), 3'b000};
    m2_raw = {1'b1, (swap ? a[51:0] : b[51:0]), 3'b000};
    d      = e1 - e2;
    // Three extra bits (guard/round/sticky) below the mantissa; shifted-out bits fold into bit 0.
    if (d >= 11'd56) begin
      m2 = 56'd1;
    end else begin
      m2    = m2_raw >> d;
      m2[0] = m2[0] | (|(m2_raw & ~({56{1'b1}} << d)));
    end
    sum = (s1 == s2) ? {1'b0, m1} + {1'b0, m2} : {1'b0, m1} - {1'b0, m2};
    e   = $signed({2'b00, e1});
    lz  = '0;
    if (sum[56]) begin
      n    = sum[56:1];
      n[0] = n[0] | sum[0];
      e    = e + 13'sd1;
    end else begin
      n     = sum[55:0];
      found = 1'b0;
      for (int i = 55; i >= 0; i--) begin
        if (!found) begin
          if (n[i]) found = 1'b1;
          else      lz = lz + 6'd1;
        end
      end
      n = n << lz;
      e = e - $signed({7'd0, lz});
    end
    res = fp_round(s1, e, n[55:3], n[2], |n[1:0]);
    if (a_nan || b_nan || (a_inf && b_inf && (a[63] != b[63]))) res = QNaN;
    else if (a_inf)                                             res = a;
    else if (b_inf)                                             res = b;
    else if (a_zero && b_zero)                                  res = {a[63] & b[63], 63'd0};
    else if (a_zero)                                            res = b;
    else if (b_zero)                                            res = a;
    else if (sum == '0)                                         res = '0;
    return res;
  endfunction

  // Datapath shift chains (no reset) and control line.
  f64_t             x1_q [MUL_LAT], x1_d [MUL_LAT];
  f64_t             x2_q [MUL_LAT], x2_d [MUL_LAT];
  f64_t             t1_q [T1Lat],   t1_d [T1Lat];
  f64_t             t2_q [ADD_LAT], t2_d [ADD_LAT];
  f64_t             a_q  [ADD_LAT], a_d  [ADD_LAT];
  logic [TAG_W-1:0] tag_q [PipeLat], tag_d [PipeLat];
  logic [1:0]       mode_q [PipeLat], mode_d [PipeLat];
  logic [PipeLat-1:0] vld_q, vld_d;
  f64_t             t1_op, t2_op;
  logic             accept;

  assign accept = in_valid & in_ready;

  always_comb begin
    t1_op = t1_q[T1Lat-1];
    t2_op = t2_q[ADD_LAT-1];
    case (mode_q[T1Lat-1])
      2'd1:    t2_op[63] = ~t2_op[63];
      2'd2:    t1_op     = '0;
      2'd3:    t2_op     = '0;
      default: ;
    endcase
    x1_d[0]   = fp_mul(coef_b, theta_b);
    x2_d[0]   = fp_mul(coef_c, theta_c);
    t1_d[0]   = fp_add(theta_a, q_a);
    t2_d[0]   = fp_add(x1_q[MUL_LAT-1], x2_q[MUL_LAT-1]);
    a_d[0]    = fp_add(t1_op, t2_op);
    tag_d[0]  = in_tag;
    mode_d[0] = in_mode;
    vld_d     = {vld_q[PipeLat-2:0], accept};
    for (int i = 1; i < int'(MUL_LAT); i++) begin
      x1_d[i] = x1_q[i-1];
      x2_d[i] = x2_q[i-1];
    end
    for (int i = 1; i < int'(T1Lat); i++) t1_d[i] = t1_q[i-1];
    for (int i = 1; i < int'(ADD_LAT); i++) begin
      t2_d[i] = t2_q[i-1];
      a_d[i]  = a_q[i-1];
    end
    for (int i = 1; i < int'(PipeLat); i++) begin
      tag_d[i]  = tag_q[i-1];
      mode_d[i] = mode_q[i-1];
    end
  end

  // Output FIFO: storage array plus a registered head; count covers both.
  f64_t             mem_a   [FIFO_DEPTH];
  logic [TAG_W-1:0] mem_tag [FIFO_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d, inflight_q, inflight_d;
  logic             out_valid_q, out_valid_d;
  f64_t             out_a_q, out_a_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             wr_en, pop, load, mem_nonempty;
  logic [CntW:0]    credits;

  always_comb begin
    wr_en        = vld_q[PipeLat-1];
    pop          = out_valid_q & out_ready;
    mem_nonempty = count_q != CntW'(out_valid_q);
    load         = mem_nonempty & (~out_valid_q | pop);
    wr_ptr_d     = wr_en ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d     = load ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d      = count_q + CntW'(wr_en) - CntW'(pop);
    inflight_d   = inflight_q + CntW'(accept) - CntW'(wr_en);
    out_valid_d  = load | (out_valid_q & ~pop);
    out_a_d      = load ? mem_a[rd_ptr_q] : out_a_q;
    out_tag_d    = load ? mem_tag[rd_ptr_q] : out_tag_q;
    credits      = {1'b0, inflight_q} + {1'b0, count_q};
  end

  always_ff @(posedge clk) begin
    x1_q   <= x1_d;
    x2_q   <= x2_d;
    t1_q   <= t1_d;
    t2_q   <= t2_d;
    a_q    <= a_d;
    tag_q  <= tag_d;
    mode_q <= mode_d;
    if (wr_en) begin
      mem_a[wr_ptr_q]   <= a_q[ADD_LAT-1];
      mem_tag[wr_ptr_q] <= tag_q[PipeLat-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      inflight_q  <= '0;
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_tag_q   <= '0;
    end else begin
      vld_q       <= vld_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      inflight_q  <= inflight_d;
      out_valid_q <= out_valid_d;
      out_a_q     <= out_a_d;
      out_tag_q   <= out_tag_d;
    end
  end

  // Depends on registered counters only, so the FIFO can never be overrun.
  assign in_ready  = credits < (CntW + 1)'(FIFO_DEPTH);
  assign out_valid = out_valid_q;
  assign out_a     = out_a_q;
  assign out_tag   = out_tag_q;
  assign busy      = (inflight_q != '0) | (count_q != '0);

endmodule

// File: tb/tb_cmu_phi_pipe.sv
// Scoreboard bench for cmu_phi_pipe: driver pushes expected results, a monitor pops on output.
module tb_cmu_phi_pipe;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready, busy;
  logic [3:0]  in_tag, out_tag;
  logic [1:0]  in_mode;
  logic [63:0] theta_a, q_a, theta_b, coef_b, theta_c, coef_c, out_a;

  cmu_phi_pipe dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_tag   (in_tag),
    .in_mode  (in_mode),
    .theta_a  (theta_a),
    .q_a      (q_a),
    .theta_b  (theta_b),
    .coef_b   (coef_b),
    .theta_c  (theta_c),
    .coef_c   (coef_c),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_a    (out_a),
    .out_tag  (out_tag),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  tag;
    logic [63:0] a;
  } exp_t;

  exp_t sb[$];
  int   total = 0, bad = 0;
  int   cyc = 0, acc_cyc = 0, pops = 0, first_pop = -1, last_pop = -1;
  int   rdy_mode = 0;
  real  vals[16];

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic real p2(input int e);
    real r = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
    else        for (int i = 0; i < -e; i++) r = r * 0.5;
    return r;
  endfunction

  // Reference model in host double arithmetic; products of table values are exact.
  function automatic logic [63:0] model(input logic [1:0] mode, input real ta, input real qa,
                                        input real tb, input real cb, input real tc,
                                        input real cc);
    real t1, x1, x2, t2, r;
    t1 = ta + qa;
    x1 = cb * tb;
    x2 = cc * tc;
    t2 = x1 + x2;
    case (mode)
      2'd0:    r = t1 + t2;
      2'd1:    r = t1 - t2;
      2'd2:    r = 0.0 + t2;
      default: r = t1 + 0.0;
    endcase
    return $realtobits(r);
  endfunction

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 1) == 1);
      endcase
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: compares on every pop and checks output stability while stalled.
  initial begin
    logic        hold_v;
    logic [67:0] hold_val;
    exp_t        e;
    hold_v = 1'b0;
    hold_val = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v && out_valid) check("stall_hold", {out_tag, out_a}, hold_val);
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_out: got %h expected no output", {out_tag, out_a});
          end else begin
            e = sb.pop_front();
            check("result", {out_tag, out_a}, {e.tag, e.a});
            pops++;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
          end
        end
        hold_v   = out_valid && !out_ready;
        hold_val = {out_tag, out_a};
      end
    end
  end

  task automatic set_default(input logic [1:0] mode);
    in_mode = mode;
    theta_a = $realtobits(1.0);
    q_a     = $realtobits(0.5);
    coef_b  = $realtobits(2.0);
    theta_b = $realtobits(3.0);
    coef_c  = $realtobits(0.5);
    theta_c = $realtobits(4.0);
  endtask

  task automatic set_tab(input logic [1:0] mode, input int ia, input int iq, input int ib,
                         input int icb, input int ic, input int icc,
                         output logic [63:0] exp_a);
    in_mode = mode;
    theta_a = $realtobits(vals[ia]);
    q_a     = $realtobits(vals[iq]);
    theta_b = $realtobits(vals[ib]);
    coef_b  = $realtobits(vals[icb]);
    theta_c = $realtobits(vals[ic]);
    coef_c  = $realtobits(vals[icc]);
    exp_a   = model(mode, vals[ia], vals[iq], vals[ib], vals[icb], vals[ic], vals[icc]);
  endtask

  // Called at posedge+1 with operands driven; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [3:0] tag, input logic [63:0] exp_a, output int stalls);
    logic acc = 1'b0;
    exp_t e;
    stalls   = 0;
    in_valid = 1'b1;
    in_tag   = tag;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) begin
        e.tag = tag;
        e.a   = exp_a;
        sb.push_back(e);
      end else begin
        stalls++;
      end
      @(posedge clk);
      #1;
      if (!acc && stalls > 500) begin
        check("accept_timeout", 68'(stalls), 68'(0));
        break;
      end
    end
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, 68'(sb.size()), 68'(0));
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int          st, st_sum, lat, acc, cnt, p0;
    logic        rdy16;
    logic [63:0] ex;
    int          mants[8] = '{1, 3, 5, 7, -3, 11, 13, -1};
    int          exps[4]  = '{-40, -3, 0, 2};
    for (int i = 0; i < 16; i++) vals[i] = real'(mants[i % 8]) * p2(exps[(i / 4) % 4]);

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_tag = '0;
    set_default(2'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 68'(out_valid), 68'(0));
    check("rst_out_a", 68'(out_a), 68'(0));
    check("rst_out_tag", 68'(out_tag), 68'(0));
    check("rst_busy", 68'(busy), 68'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 68'(in_ready), 68'(1));
    @(posedge clk);
    #1;

    // T1: single transaction, latency
    rdy_mode = 1;
    set_default(2'd0);
    send(4'd0, 64'h4023_0000_0000_0000, st);
    lat = -1;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = cyc - acc_cyc;
        break;
      end
    end
    check("t1_latency", 68'(lat), 68'(11));
    @(posedge clk);
    #1;
    drain("t1_drain");

    // T2: modes 1,2,3 back to back
    set_default(2'd1);
    send(4'd1, 64'hC01A_0000_0000_0000, st);
    set_default(2'd2);
    send(4'd2, 64'h4020_0000_0000_0000, st);
    set_default(2'd3);
    send(4'd3, 64'h3FF8_0000_0000_0000, st);
    drain("t2_drain");

    // T3: 64 back-to-back at full rate
    p0 = pops;
    first_pop = -1;
    st_sum = 0;
    for (int i = 0; i < 64; i++) begin
      set_tab(2'(i % 4), i % 16, (i * 3) % 16, (i * 5) % 16, (i + 7) % 16, (i * 11) % 16,
              (i + 2) % 16, ex);
      send(4'(i), ex, st);
      st_sum += st;
    end
    drain("t3_drain");
    check("t3_in_ready_stalls", 68'(st_sum), 68'(0));
    check("t3_pop_count", 68'(pops - p0), 68'(64));
    check("t3_consecutive", 68'(last_pop - first_pop), 68'(63));

    // T4: fill with consumer stalled
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    p0 = pops;
    acc = 0;
    rdy16 = 1'b1;
    for (int i = 0; i < 24; i++) begin
      exp_t e;
      set_tab(2'd0, i % 16, (i + 1) % 16, (i + 2) % 16, (i + 3) % 16, (i + 4) % 16,
              (i + 5) % 16, ex);
      in_valid = 1'b1;
      in_tag = 4'(i);
      @(negedge clk);
      if (i == 16) rdy16 = in_ready;
      if (in_ready) begin
        e.tag = 4'(i);
        e.a = ex;
        sb.push_back(e);
        acc++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("t4_accepted", 68'(acc), 68'(16));
    check("t4_ready_17th", 68'(rdy16), 68'(0));
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("t4_ready_full", 68'(in_ready), 68'(0));
    rdy_mode = 1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      if (out_ready) break;
    end
    @(posedge clk);
    @(negedge clk);
    check("t4_ready_after_pop", 68'(in_ready), 68'(1));
    @(posedge clk);
    #1;
    drain("t4_drain");
    check("t4_pop_count", 68'(pops - p0), 68'(16));

    // T5: random valid/ready with table operands
    rdy_mode = 2;
    p0 = pops;
    for (int i = 0; i < 2000; i++) begin
      while ($urandom_range(0, 1) == 0) begin
        @(posedge clk);
        #1;
      end
      set_tab(2'($urandom_range(0, 3)), $urandom_range(0, 15), $urandom_range(0, 15),
              $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
              $urandom_range(0, 15), ex);
      send(4'(i), ex, st);
    end
    drain("t5_drain");
    check("t5_pop_count", 68'(pops - p0), 68'(2000));

    // T6: reset with 8 in flight and 5 in the FIFO
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    set_default(2'd0);
    for (int i = 0; i < 5; i++) send(4'(i), 64'h4023_0000_0000_0000, st);
    repeat (15) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) send(4'(i + 8), 64'h4023_0000_0000_0000, st);
    check("t6_busy_pre", 68'(busy), 68'(1));
    rst_n = 1'b0;
    #1;
    check("t6_rst_out_valid", 68'(out_valid), 68'(0));
    check("t6_rst_busy", 68'(busy), 68'(0));
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_in_ready", 68'(in_ready), 68'(1));
    rdy_mode = 1;
    cnt = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("t6_no_stale", 68'(cnt), 68'(0));
    @(posedge clk);
    #1;
    set_default(2'd0);
    send(4'd5, 64'h4023_0000_0000_0000, st);
    drain("t6_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
